// File: rtl/retire_map_if.sv
// Retire-to-map bus: ROB-head retire group in, freed-register packet and committed map out.
// Latency: n/a (wiring only).
// Backpressure: none; every retire group and freed packet is consumed the cycle it is presented.

`ifndef N
`define N 4
`endif
`ifndef ARCH_REG_SZ
`define ARCH_REG_SZ 32
`endif
`ifndef PHYS_REG_SZ
`define PHYS_REG_SZ 64
`endif

// One freed physical register as seen by the free list write port.
typedef struct packed {
    logic [$clog2(`PHYS_REG_SZ)-1:0] reg_idx;
    logic                            valid;
} FREE_LIST_PACKET;

interface retire_map_if #(
    parameter int N           = `N,
    parameter int ARCH_REG_SZ = `ARCH_REG_SZ,
    parameter int PHYS_REG_SZ = `PHYS_REG_SZ
);
    localparam int NW = $clog2(N + 1);
    localparam int AW = $clog2(ARCH_REG_SZ);
    localparam int PW = $clog2(PHYS_REG_SZ);

    logic [NW-1:0]                   retire_num;
    logic [N-1:0][AW-1:0]            retire_arch;
    logic [N-1:0][PW-1:0]            retire_phys;
    logic [NW-1:0]                   free_num;
    FREE_LIST_PACKET [N-1:0]         free_reg;
    logic [ARCH_REG_SZ-1:0][PW-1:0]  arch_map;

    // ROB / test side: drives the retire group, observes freed regs and the map.
    modport master (
        output retire_num, retire_arch, retire_phys,
        input  free_num, free_reg, arch_map
    );

    // Map table side.
    modport slave (
        input  retire_num, retire_arch, retire_phys,
        output free_num, free_reg, arch_map
    );
endinterface

// File: rtl/retire_map.sv
// Committed arch->phys map; turns each retire group into a compacted packet of displaced phys regs.
// Latency: 1 cycle from retire group to map update and freed-register packet.
// Backpressure: none; a group is absorbed every cycle and the packet is held for exactly one cycle.

module retire_map #(
    parameter int N           = `N,
    parameter int ARCH_REG_SZ = `ARCH_REG_SZ,
    parameter int PHYS_REG_SZ = `PHYS_REG_SZ
) (
    input  logic         clock,
    input  logic         reset,
    retire_map_if.slave  bus
);
    localparam int NW = $clog2(N + 1);
    localparam int PW = $clog2(PHYS_REG_SZ);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [ARCH_REG_SZ-1:0][PW-1:0] r_map;
    logic [NW-1:0]                  r_free_num;
    FREE_LIST_PACKET [N-1:0]        r_free_reg;

    logic [ARCH_REG_SZ-1:0][PW-1:0] w_map;
    logic [NW-1:0]                  w_free_num;
    FREE_LIST_PACKET [N-1:0]        w_free_reg;
    int                             w_cnt;

    // Walk slots in program order against a running copy of the map: reading the
    // running copy gives each slot the phys written by the latest earlier same-arch
    // slot (or the committed one), and the last writer of an arch wins. Slots at or
    // above retire_num are ignored, which also clamps retire_num > N. Arch 0 has no
    // destination and is skipped without leaving a gap in the packet.
    always_comb begin
        w_map      = r_map;
        w_free_reg = '0;
        w_cnt      = 0;
        for (int i = 0; i < N; i++) begin
            if ((NW'(i) < bus.retire_num) && (bus.retire_arch[i] != '0)) begin
                w_free_reg[IW'(w_cnt)].reg_idx = w_map[bus.retire_arch[i]];
                w_free_reg[IW'(w_cnt)].valid   = 1'b1;
                w_cnt                          = w_cnt + 1;
                w_map[bus.retire_arch[i]]      = bus.retire_phys[i];
            end
        end
        w_free_num = NW'(w_cnt);
    end

    // Commit the map and register the freed packet; reset restores the identity
    // map and drops any pending packet, matching the free list reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < ARCH_REG_SZ; i++) begin
                r_map[i] <= PW'(i);
            end
            r_free_num <= '0;
            r_free_reg <= '0;
        end else begin
            r_map      <= w_map;
            r_free_num <= w_free_num;
            r_free_reg <= w_free_reg;
        end
    end

    assign bus.arch_map = r_map;
    assign bus.free_num = r_free_num;
    assign bus.free_reg = r_free_reg;
endmodule

// File: tb/tb_retire_map.sv
// Directed bench for retire_map: reset, forwarding, skip, clamping, back-to-back and mid-stream reset.
// Latency: checks every output one cycle after its retire group.
// Backpressure: none exercised; the block never stalls.

module tb_retire_map;
    localparam int N  = 4;
    localparam int AR = 32;
    localparam int PR = 64;
    localparam int PW = $clog2(PR);

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_bad;

    logic [AR-1:0][PW-1:0] exp_map;

    retire_map_if #(.N(N), .ARCH_REG_SZ(AR), .PHYS_REG_SZ(PR)) bus ();

    retire_map #(.N(N), .ARCH_REG_SZ(AR), .PHYS_REG_SZ(PR)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic FREE_LIST_PACKET pk(input int idx);
        FREE_LIST_PACKET p;
        p.reg_idx = PW'(idx);
        p.valid   = 1'b1;
        return p;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_slot(input int s, input int a, input int p);
        bus.retire_arch[s] = 5'(a);
        bus.retire_phys[s] = PW'(p);
    endtask

    // Advance one edge, then sample 1 time unit later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;

        // Reset held for two cycles with a full garbage retire group.
        reset = 1'b0;
        bus.retire_num = 3'd4;
        set_slot(0, 3, 33); set_slot(1, 6, 34); set_slot(2, 3, 35); set_slot(3, 9, 36);
        tick();
        tick();
        for (int i = 0; i < AR; i++) exp_map[i] = PW'(i);
        chk("reset_map", 256'(bus.arch_map), 256'(exp_map));
        chk("reset_free_num", 256'(bus.free_num), 256'(0));
        chk("reset_free_reg", 256'(bus.free_reg), 256'(0));

        // Single retire 3->40: frees 3.
        reset = 1'b1;
        bus.retire_arch = '0;
        bus.retire_phys = '0;
        bus.retire_num = 3'd1;
        set_slot(0, 3, 40);
        tick();
        chk("single_num", 256'(bus.free_num), 256'(1));
        chk("single_reg0", 256'(bus.free_reg[0]), 256'(pk(3)));
        chk("single_upper", 256'(bus.free_reg[3:1]), 256'(0));
        chk("single_map3", 256'(bus.arch_map[3]), 256'(40));

        // Same-arch chain 5->41,42,43: frees 5,41,42.
        bus.retire_num = 3'd3;
        set_slot(0, 5, 41); set_slot(1, 5, 42); set_slot(2, 5, 43); set_slot(3, 0, 0);
        tick();
        chk("chain_num", 256'(bus.free_num), 256'(3));
        chk("chain_reg0", 256'(bus.free_reg[0]), 256'(pk(5)));
        chk("chain_reg1", 256'(bus.free_reg[1]), 256'(pk(41)));
        chk("chain_reg2", 256'(bus.free_reg[2]), 256'(pk(42)));
        chk("chain_reg3", 256'(bus.free_reg[3]), 256'(0));
        chk("chain_map5", 256'(bus.arch_map[5]), 256'(43));

        // Arch 0 skipped: 0->44, 7->45 frees only 7.
        bus.retire_num = 3'd2;
        set_slot(0, 0, 44); set_slot(1, 7, 45);
        tick();
        chk("skip_num", 256'(bus.free_num), 256'(1));
        chk("skip_reg0", 256'(bus.free_reg[0]), 256'(pk(7)));
        chk("skip_reg1", 256'(bus.free_reg[1]), 256'(0));
        chk("skip_map0", 256'(bus.arch_map[0]), 256'(0));
        chk("skip_map7", 256'(bus.arch_map[7]), 256'(45));

        // Back-to-back 2->50, 2->51, then an empty cycle.
        bus.retire_num = 3'd1;
        set_slot(0, 2, 50); set_slot(1, 0, 0); set_slot(2, 0, 0);
        tick();
        chk("b2b0_num", 256'(bus.free_num), 256'(1));
        chk("b2b0_reg0", 256'(bus.free_reg[0]), 256'(pk(2)));
        set_slot(0, 2, 51);
        tick();
        chk("b2b1_reg0", 256'(bus.free_reg[0]), 256'(pk(50)));
        bus.retire_num = 3'd0;
        tick();
        chk("b2b2_num", 256'(bus.free_num), 256'(0));
        chk("b2b2_reg", 256'(bus.free_reg), 256'(0));
        chk("b2b2_map2", 256'(bus.arch_map[2]), 256'(51));

        // retire_num=7 clamps to 4: 8->52, 9->53, 8->54 (frees 52), slot 3 arch 0.
        bus.retire_num = 3'd7;
        set_slot(0, 8, 52); set_slot(1, 9, 53); set_slot(2, 8, 54); set_slot(3, 0, 1);
        tick();
        chk("clamp_num", 256'(bus.free_num), 256'(3));
        chk("clamp_reg0", 256'(bus.free_reg[0]), 256'(pk(8)));
        chk("clamp_reg1", 256'(bus.free_reg[1]), 256'(pk(9)));
        chk("clamp_reg2", 256'(bus.free_reg[2]), 256'(pk(52)));
        chk("clamp_reg3", 256'(bus.free_reg[3]), 256'(0));
        exp_map[3] = 6'd40; exp_map[5] = 6'd43; exp_map[7] = 6'd45;
        exp_map[2] = 6'd51; exp_map[8] = 6'd54; exp_map[9] = 6'd53;
        chk("full_map", 256'(bus.arch_map), 256'(exp_map));

        // Mid-stream reset: 4->60 retires, then reset drops the next group.
        bus.retire_num = 3'd1;
        set_slot(0, 4, 60); set_slot(1, 0, 0); set_slot(2, 0, 0); set_slot(3, 0, 0);
        tick();
        chk("mid_reg0", 256'(bus.free_reg[0]), 256'(pk(4)));
        chk("mid_map4", 256'(bus.arch_map[4]), 256'(60));
        reset = 1'b0;
        set_slot(0, 4, 61);
        tick();
        chk("rst_num", 256'(bus.free_num), 256'(0));
        chk("rst_reg", 256'(bus.free_reg), 256'(0));
        chk("rst_map4", 256'(bus.arch_map[4]), 256'(4));
        chk("rst_map2", 256'(bus.arch_map[2]), 256'(2));

        // First cycle out of reset retires normally: 4->61 frees 4.
        reset = 1'b1;
        tick();
        chk("post_num", 256'(bus.free_num), 256'(1));
        chk("post_reg0", 256'(bus.free_reg[0]), 256'(pk(4)));
        chk("post_map4", 256'(bus.arch_map[4]), 256'(61));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
